// File: rtl/cmd_decoder.sv
// Byte-serial command decoder: pulls bytes from the shared register and issues
// 16-bit word writes (single or burst fill) into the line buffer.
module cmd_decoder #(
   parameter int unsigned LINE_WORDS = 50
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        has_data,
   input  logic [7:0]  rd_data,
   output logic        rd,
   output logic        lb_wr,
   output logic [7:0]  lb_wr_addr,
   output logic [15:0] lb_wr_data,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_OPC, ST_ADDR, ST_WHI, ST_WLO, ST_FCNT, ST_FHI, ST_FLO, ST_FILL
   } state_e;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_SETADDR = 8'h01;
   localparam logic [7:0] OP_WRITE   = 8'h02;
   localparam logic [7:0] OP_FILL    = 8'h03;
   localparam logic [7:0] LAST_ADDR  = 8'(LINE_WORDS - 1);
   localparam logic [8:0] LINE_W9    = 9'(LINE_WORDS);

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] data_q, data_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        accept;

   // A byte is taken only when the previous acknowledge has retired and no burst is running.
   assign accept = has_data && !rd_q && (state_q != ST_FILL);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b0;

      if (wr_q) begin
         addr_d = (addr_q >= LAST_ADDR) ? 8'h00 : addr_q + 8'h01;
      end

      if (state_q == ST_FILL) begin
         cnt_d = cnt_q - 8'h01;
         if (cnt_q == 8'h01) begin
            state_d = ST_OPC;
         end else begin
            wr_d   = 1'b1;
            busy_d = 1'b1;
         end
      end else if (accept) begin
         rd_d = 1'b1;
         case (state_q)
            ST_OPC: begin
               case (rd_data)
                  OP_NOP:     state_d = ST_OPC;
                  OP_SETADDR: state_d = ST_ADDR;
                  OP_WRITE:   state_d = ST_WHI;
                  OP_FILL:    state_d = ST_FCNT;
                  default:    err_d   = 1'b1;
               endcase
            end
            ST_ADDR: begin
               state_d = ST_OPC;
               if ({1'b0, rd_data} >= LINE_W9) begin
                  addr_d = 8'h00;
                  err_d  = 1'b1;
               end else begin
                  addr_d = rd_data;
               end
            end
            ST_WHI: begin
               hi_d    = rd_data;
               state_d = ST_WLO;
            end
            ST_WLO: begin
               data_d  = {hi_q, rd_data};
               wr_d    = 1'b1;
               state_d = ST_OPC;
            end
            ST_FCNT: begin
               cnt_d   = rd_data;
               state_d = ST_FHI;
            end
            ST_FHI: begin
               hi_d    = rd_data;
               state_d = ST_FLO;
            end
            ST_FLO: begin
               // A zero-length fill consumes its operands and writes nothing.
               if (cnt_q == 8'h00) begin
                  state_d = ST_OPC;
               end else begin
                  data_d  = {hi_q, rd_data};
                  wr_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ST_FILL;
               end
            end
            default: state_d = ST_OPC;
         endcase
      end
   end

   // NOTE: reset is synchronous and active-high on nrst; state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q <= ST_OPC;
         addr_q  <= 8'h00;
         hi_q    <= 8'h00;
         cnt_q   <= 8'h00;
         data_q  <= 16'h0000;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign rd         = rd_q;
   assign lb_wr      = wr_q;
   assign lb_wr_addr = addr_q;
   assign lb_wr_data = data_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: drives the shared-register handshake and
// checks line buffer writes, addressing, FILL bursts, errors and mid-burst reset.
module tb_cmd_decoder;

   logic        clk = 1'b0;
   logic        nrst;
   logic        has_data;
   logic [7:0]  rd_data;
   logic        rd;
   logic        lb_wr;
   logic [7:0]  lb_wr_addr;
   logic [15:0] lb_wr_data;
   logic        busy;
   logic        err;

   int vectors    = 0;
   int miscompares = 0;

   int rd_cnt   = 0;
   int err_cnt  = 0;
   int busy_cnt = 0;
   int wr_cnt   = 0;
   logic [7:0]  wr_addr_q[$];
   logic [15:0] wr_data_q[$];

   cmd_decoder #(.LINE_WORDS(50)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .has_data   (has_data),
      .rd_data    (rd_data),
      .rd         (rd),
      .lb_wr      (lb_wr),
      .lb_wr_addr (lb_wr_addr),
      .lb_wr_data (lb_wr_data),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Passive monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (rd)    rd_cnt++;
      if (err)   err_cnt++;
      if (busy)  busy_cnt++;
      if (lb_wr) begin
         wr_cnt++;
         wr_addr_q.push_back(lb_wr_addr);
         wr_data_q.push_back(lb_wr_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Present a byte and return 1ns into the cycle in which rd is high.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(posedge clk); #1;
      has_data = 1'b1;
      rd_data  = b;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!rd && n < 20);
      if (!rd) begin
         vectors++; miscompares++;
         $display("FAIL handshake byte %h never acknowledged", b);
      end
      has_data = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      nrst = 1'b1; has_data = 1'b0; rd_data = 8'h00;
      idle(3);
      vectors++;
      if ({rd, lb_wr, lb_wr_addr, lb_wr_data, busy, err} !== 28'h0) begin
         miscompares++;
         $display("FAIL reset_outputs got rd=%b wr=%b addr=%h data=%h busy=%b err=%b exp all 0",
                  rd, lb_wr, lb_wr_addr, lb_wr_data, busy, err);
      end
      nrst = 1'b0;
      idle(1);
   endtask

   task automatic test_write;
      int rd0, wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      send_byte(8'h02); send_byte(8'h80); send_byte(8'h01);
      vectors++;
      if (lb_wr !== 1'b1 || lb_wr_addr !== 8'd0 || lb_wr_data !== 16'h8001) begin
         miscompares++;
         $display("FAIL write_pulse got wr=%b addr=%0d data=%h exp wr=1 addr=0 data=8001",
                  lb_wr, lb_wr_addr, lb_wr_data);
      end
      idle(1);
      vectors++;
      if (lb_wr !== 1'b0 || lb_wr_addr !== 8'd1) begin
         miscompares++;
         $display("FAIL write_after got wr=%b addr=%0d exp wr=0 addr=1", lb_wr, lb_wr_addr);
      end
      idle(2);
      vectors++;
      if (rd_cnt - rd0 != 3 || wr_cnt - wr0 != 1) begin
         miscompares++;
         $display("FAIL write_counts got rd=%0d wr=%0d exp rd=3 wr=1", rd_cnt - rd0, wr_cnt - wr0);
      end
   endtask

   task automatic test_wrap;
      int e0;
      e0 = err_cnt;
      send_byte(8'h01); send_byte(8'd49);
      vectors++;
      if (lb_wr_addr !== 8'd49) begin
         miscompares++;
         $display("FAIL setaddr_49 got %0d exp 49", lb_wr_addr);
      end
      send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
      vectors++;
      if (lb_wr !== 1'b1 || lb_wr_addr !== 8'd49 || lb_wr_data !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL wrap_w1 got wr=%b addr=%0d data=%h exp wr=1 addr=49 data=ffff",
                  lb_wr, lb_wr_addr, lb_wr_data);
      end
      send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
      vectors++;
      if (lb_wr !== 1'b1 || lb_wr_addr !== 8'd0) begin
         miscompares++;
         $display("FAIL wrap_w2 got wr=%b addr=%0d exp wr=1 addr=0", lb_wr, lb_wr_addr);
      end
      idle(1);
      vectors++;
      if (lb_wr_addr !== 8'd1 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL wrap_final got addr=%0d errs=%0d exp addr=1 errs=0", lb_wr_addr, err_cnt - e0);
      end
   endtask

   task automatic test_fill;
      int got_rd;
      send_byte(8'h01); send_byte(8'd10);
      send_byte(8'h03); send_byte(8'd5); send_byte(8'hAA); send_byte(8'h55);
      has_data = 1'b1; rd_data = 8'h00;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (lb_wr !== 1'b1 || busy !== 1'b1 || lb_wr_addr !== 8'(10 + k) ||
             lb_wr_data !== 16'hAA55 || (k > 0 && rd !== 1'b0)) begin
            miscompares++;
            $display("FAIL fill_cycle%0d got wr=%b busy=%b addr=%0d data=%h rd=%b exp wr=1 busy=1 addr=%0d data=aa55 rd=0",
                     k, lb_wr, busy, lb_wr_addr, lb_wr_data, rd, 10 + k);
         end
         idle(1);
      end
      vectors++;
      if (lb_wr !== 1'b0 || busy !== 1'b0 || lb_wr_addr !== 8'd15 || rd !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_exit got wr=%b busy=%b addr=%0d rd=%b exp wr=0 busy=0 addr=15 rd=0",
                  lb_wr, busy, lb_wr_addr, rd);
      end
      got_rd = 0;
      for (int k = 0; k < 3 && got_rd == 0; k++) begin
         idle(1);
         if (rd) got_rd = 1;
      end
      has_data = 1'b0;
      vectors++;
      if (got_rd != 1) begin
         miscompares++;
         $display("FAIL fill_pending_byte got rd=0 exp rd within 3 cycles of exit");
      end
      idle(1);
   endtask

   task automatic test_errors;
      int e0, w0;
      e0 = err_cnt; w0 = wr_cnt;
      send_byte(8'h7E);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL err_opcode got %b exp 1", err);
      end
      idle(1);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_single_cycle got %b exp 0", err);
      end
      send_byte(8'h01); send_byte(8'd60);
      vectors++;
      if (err !== 1'b1 || lb_wr_addr !== 8'd0) begin
         miscompares++;
         $display("FAIL err_setaddr got err=%b addr=%0d exp err=1 addr=0", err, lb_wr_addr);
      end
      idle(2);
      vectors++;
      if (err_cnt - e0 != 2 || wr_cnt != w0) begin
         miscompares++;
         $display("FAIL err_counts got errs=%0d writes=%0d exp errs=2 writes=0", err_cnt - e0, wr_cnt - w0);
      end
      send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
      vectors++;
      if (lb_wr !== 1'b1 || lb_wr_addr !== 8'd0 || lb_wr_data !== 16'h1234) begin
         miscompares++;
         $display("FAIL err_recover got wr=%b addr=%0d data=%h exp wr=1 addr=0 data=1234",
                  lb_wr, lb_wr_addr, lb_wr_data);
      end
      idle(2);
      vectors++;
      if (err_cnt - e0 != 2) begin
         miscompares++;
         $display("FAIL err_recover_errs got %0d exp 2", err_cnt - e0);
      end
   endtask

   task automatic test_fill_edges;
      int w0, b0, q0;
      w0 = wr_cnt; b0 = busy_cnt;
      send_byte(8'h03); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
      idle(3);
      vectors++;
      if (wr_cnt != w0 || busy_cnt != b0 || lb_wr_addr !== 8'd1) begin
         miscompares++;
         $display("FAIL fill_zero got writes=%0d busy=%0d addr=%0d exp writes=0 busy=0 addr=1",
                  wr_cnt - w0, busy_cnt - b0, lb_wr_addr);
      end
      send_byte(8'h01); send_byte(8'h00);
      w0 = wr_cnt; b0 = busy_cnt; q0 = wr_addr_q.size();
      send_byte(8'h03); send_byte(8'd60); send_byte(8'hA5); send_byte(8'h5A);
      idle(65);
      vectors++;
      if (wr_cnt - w0 != 60 || busy_cnt - b0 != 60 || lb_wr_addr !== 8'd10) begin
         miscompares++;
         $display("FAIL fill_60 got writes=%0d busy=%0d addr=%0d exp writes=60 busy=60 addr=10",
                  wr_cnt - w0, busy_cnt - b0, lb_wr_addr);
      end
      vectors++;
      if (wr_addr_q.size() < q0 + 60 || wr_addr_q[q0 + 49] !== 8'd49 || wr_addr_q[q0 + 50] !== 8'd0 ||
          wr_addr_q[q0 + 59] !== 8'd9 || wr_data_q[q0 + 59] !== 16'hA55A) begin
         miscompares++;
         $display("FAIL fill_60_wrap_sequence exp addr 49 then 0 ... 9 with data a55a");
      end
   endtask

   task automatic test_reset_mid_fill;
      int w0;
      send_byte(8'h03); send_byte(8'd20); send_byte(8'h00); send_byte(8'hFF);
      idle(2);
      nrst = 1'b1;
      idle(1);
      vectors++;
      if (lb_wr !== 1'b0 || busy !== 1'b0 || lb_wr_addr !== 8'd0 || lb_wr_data !== 16'h0 ||
          rd !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_fill got wr=%b busy=%b addr=%0d data=%h rd=%b err=%b exp all 0",
                  lb_wr, busy, lb_wr_addr, lb_wr_data, rd, err);
      end
      nrst = 1'b0;
      w0 = wr_cnt;
      idle(5);
      vectors++;
      if (wr_cnt != w0) begin
         miscompares++;
         $display("FAIL reset_no_more_writes got %0d exp 0", wr_cnt - w0);
      end
      send_byte(8'h02); send_byte(8'h0B); send_byte(8'hCD);
      vectors++;
      if (lb_wr !== 1'b1 || lb_wr_addr !== 8'd0 || lb_wr_data !== 16'h0BCD) begin
         miscompares++;
         $display("FAIL reset_then_write got wr=%b addr=%0d data=%h exp wr=1 addr=0 data=0bcd",
                  lb_wr, lb_wr_addr, lb_wr_data);
      end
      idle(2);
   endtask

   initial begin
      test_reset;
      test_write;
      test_wrap;
      test_fill;
      test_errors;
      test_fill_edges;
      test_reset_mid_fill;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
